// File: rtl/fetch_decode_queue_if.sv
// Valid/ready channel carrying one fetched instruction with its prediction metadata.
// The fetch-to-queue and queue-to-decode sides each use one instance.
interface fetch_decode_queue_if #(
  parameter int unsigned W_PC  = 32,
  parameter int unsigned W_PHT = 10
);
  logic             valid;
  logic             ready;
  logic [31:0]      insn;
  logic [W_PC-1:0]  pc;
  logic             pred;
  logic [W_PHT-1:0] pht_idx;
  logic [W_PC-1:0]  pred_target;

  modport master (
    output valid, insn, pc, pred, pht_idx, pred_target,
    input  ready
  );

  modport slave (
    input  valid, insn, pc, pred, pht_idx, pred_target,
    output ready
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular FIFO between instruction fetch and decode. The head entry is shown
// to decode straight from storage, and a flush drains every entry.
module fetch_decode_queue #(
  parameter int unsigned LG_DEPTH = 3,
  parameter int unsigned W_PC     = 32,
  parameter int unsigned W_PHT    = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  fetch_decode_queue_if.slave   enq,
  fetch_decode_queue_if.master  deq,
  output logic [LG_DEPTH:0]     occupancy,
  output logic [31:0]           full_cycles
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;
  localparam int unsigned PW    = LG_DEPTH + 1;

  typedef struct packed {
    logic [31:0]      insn;
    logic [W_PC-1:0]  pc;
    logic             pred;
    logic [W_PHT-1:0] pht_idx;
    logic [W_PC-1:0]  pred_target;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail, head_n, tail_n;
  logic [PW-1:0] occupancy_n;
  logic          in_ready_q, out_valid_q;
  logic          in_ready_n, out_valid_n;
  logic          enq_fire, deq_fire;
  logic [31:0]   full_cycles_n;

  assign enq_fire = enq.valid && in_ready_q && !flush;
  assign deq_fire = out_valid_q && deq.ready && !flush;

  // Next pointers, counts and flags; handshake flags derive from next state only
  always_comb begin
    head_n        = head;
    tail_n        = tail;
    occupancy_n   = occupancy;
    full_cycles_n = full_cycles;
    if (flush) begin
      head_n      = '0;
      tail_n      = '0;
      occupancy_n = '0;
    end else begin
      if (enq_fire) tail_n = tail + PW'(1);
      if (deq_fire) head_n = head + PW'(1);
      if (enq_fire && !deq_fire)      occupancy_n = occupancy + PW'(1);
      else if (!enq_fire && deq_fire) occupancy_n = occupancy - PW'(1);
      if (enq.valid && !in_ready_q && full_cycles != 32'hFFFF_FFFF)
        full_cycles_n = full_cycles + 32'd1;
    end
    out_valid_n = (head_n != tail_n);
    in_ready_n  = !((head_n[LG_DEPTH] != tail_n[LG_DEPTH]) &&
                    (head_n[LG_DEPTH-1:0] == tail_n[LG_DEPTH-1:0]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      full_cycles <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      head        <= head_n;
      tail        <= tail_n;
      occupancy   <= occupancy_n;
      full_cycles <= full_cycles_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
    end
  end

  // Entry storage is not reset; contents only matter while valid
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail[LG_DEPTH-1:0]] <= '{insn:        enq.insn,
                                   pc:          enq.pc,
                                   pred:        enq.pred,
                                   pht_idx:     enq.pht_idx,
                                   pred_target: enq.pred_target};
    end
  end

  assign enq.ready       = in_ready_q;
  assign deq.valid       = out_valid_q;
  assign deq.insn        = mem[head[LG_DEPTH-1:0]].insn;
  assign deq.pc          = mem[head[LG_DEPTH-1:0]].pc;
  assign deq.pred        = mem[head[LG_DEPTH-1:0]].pred;
  assign deq.pht_idx     = mem[head[LG_DEPTH-1:0]].pht_idx;
  assign deq.pred_target = mem[head[LG_DEPTH-1:0]].pred_target;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [3:0]  occupancy;
  logic [31:0] full_cycles;

  fetch_decode_queue_if #(.W_PC(32), .W_PHT(10)) enq_if ();
  fetch_decode_queue_if #(.W_PC(32), .W_PHT(10)) deq_if ();

  fetch_decode_queue #(.LG_DEPTH(3), .W_PC(32), .W_PHT(10)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .enq         (enq_if),
    .deq         (deq_if),
    .occupancy   (occupancy),
    .full_cycles (full_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        pred;
    logic [9:0]  pht;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic [31:0] seen[$];
  longint unsigned fc_m;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.insn = $urandom;
    e.pc   = pc;
    e.pred = 1'($urandom_range(1));
    e.pht  = 10'($urandom);
    e.tgt  = $urandom;
    return e;
  endfunction

  task automatic drive(input bit v, input ent_t e, input bit rdy, input bit fl);
    enq_if.valid       = v;
    enq_if.insn        = e.insn;
    enq_if.pc          = e.pc;
    enq_if.pred        = e.pred;
    enq_if.pht_idx     = e.pht;
    enq_if.pred_target = e.tgt;
    deq_if.ready       = rdy;
    flush              = fl;
  endtask

  task automatic check_state();
    chk("out_valid", 64'(deq_if.valid), 64'(q.size() > 0));
    chk("in_ready", 64'(enq_if.ready), 64'(q.size() < 8));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("full_cycles", 64'(full_cycles), fc_m);
    if (q.size() > 0) begin
      chk("head_insn", 64'(deq_if.insn), 64'(q[0].insn));
      chk("head_pc", 64'(deq_if.pc), 64'(q[0].pc));
      chk("head_pred", 64'(deq_if.pred), 64'(q[0].pred));
      chk("head_pht", 64'(deq_if.pht_idx), 64'(q[0].pht));
      chk("head_tgt", 64'(deq_if.pred_target), 64'(q[0].tgt));
    end
  endtask

  // Advance one clock: update the model from the inputs now applied, then compare
  task automatic step();
    int   sz;
    ent_t e;
    sz = q.size();
    e.insn = enq_if.insn;  e.pc = enq_if.pc;  e.pred = enq_if.pred;
    e.pht  = enq_if.pht_idx;  e.tgt = enq_if.pred_target;
    if (flush) begin
      q.delete();
    end else begin
      if (enq_if.valid && sz == 8 && fc_m != 64'hFFFF_FFFF) fc_m++;
      if (deq_if.ready && sz > 0) begin
        chk("deq_pc", 64'(deq_if.pc), 64'(q[0].pc));
        seen.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (enq_if.valid && sz < 8) q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  ent_t z;
  ent_t e1;
  int   k;

  initial begin
    z = '{insn: 0, pc: 0, pred: 0, pht: 0, tgt: 0};
    fc_m = 0;
    reset_n = 1'b0;
    drive(0, z, 0, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check_state();

    // 1: single enqueue, one-cycle latency, no bypass
    e1 = mk(32'h1000);
    e1.insn = 32'h0000_0013;
    drive(1, e1, 0, 0);
    #1 chk("t1_same_cycle_valid", 64'(deq_if.valid), 64'd0);
    step();
    chk("t1_insn", 64'(deq_if.insn), 64'h13);
    chk("t1_pc", 64'(deq_if.pc), 64'h1000);
    chk("t1_occ", 64'(occupancy), 64'd1);
    drive(0, z, 1, 0);
    step();

    // 2: fill to 8, then hold in_valid five cycles against a full queue
    for (int i = 0; i < 8; i++) begin
      drive(1, mk(32'h3000 + 32'(4 * i)), 0, 0);
      step();
    end
    chk("t2_occ", 64'(occupancy), 64'd8);
    chk("t2_in_ready", 64'(enq_if.ready), 64'd0);
    drive(1, mk(32'hDEAD0), 0, 0);
    repeat (5) step();
    chk("t2_full_cycles", 64'(full_cycles), 64'd5);

    // 3: dequeue while full blocks the enqueue; it lands a cycle later
    deq_if.ready = 1'b1;
    step();
    chk("t3_occ", 64'(occupancy), 64'd7);
    chk("t3_in_ready", 64'(enq_if.ready), 64'd1);
    deq_if.ready = 1'b0;
    step();
    chk("t3_refill_occ", 64'(occupancy), 64'd8);
    drive(0, z, 1, 0);
    repeat (8) step();

    // 4: stream 20 entries across the pointer wrap
    seen.delete();
    k = 0;
    for (int c = 0; c < 80 && seen.size() < 20; c++) begin
      drive(k < 20, mk(32'h1000 + 32'(4 * k)), 1, 0);
      if (k < 20 && q.size() < 8) begin
        step();
        k++;
      end else begin
        step();
      end
    end
    chk("t4_count", 64'(seen.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      if (i < seen.size()) chk("t4_order", 64'(seen[i]), 64'(32'h1000 + 32'(4 * i)));

    // 5: flush with concurrent enq and deq drops everything
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(32'h4000 + 32'(4 * i)), 0, 0);
      step();
    end
    drive(1, mk(32'hBAD0), 1, 1);
    step();
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_out_valid", 64'(deq_if.valid), 64'd0);
    chk("t5_in_ready", 64'(enq_if.ready), 64'd1);
    drive(0, z, 0, 0);
    step();
    drive(1, mk(32'h5000), 0, 0);
    step();
    chk("t5_after_pc", 64'(deq_if.pc), 64'h5000);
    drive(0, z, 1, 0);
    step();

    // 6: asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(32'h6000 + 32'(4 * i)), 0, 0);
      step();
    end
    drive(0, z, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(deq_if.valid), 64'd0);
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_in_ready", 64'(enq_if.ready), 64'd1);
    chk("t6_full_cycles", 64'(full_cycles), 64'd0);
    q.delete();
    fc_m = 0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    drive(1, mk(32'h2000), 0, 0);
    step();
    chk("t6_head_pc", 64'(deq_if.pc), 64'h2000);

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(99) < 60), mk($urandom),
            ($urandom_range(99) < 45), ($urandom_range(31) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
